// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle logical barrel shift built on the ALU's 1-bit shifter.
// The working value goes out on alu_a with a shift function code. yout/cout come
// back and are captured on each clock until the requested number of steps is done.

`ifndef ALU_F_SHIFT_LEFT
`define ALU_F_SHIFT_LEFT  5'h1A
`endif
`ifndef ALU_F_SHIFT_RIGHT
`define ALU_F_SHIFT_RIGHT 5'h1B
`endif

module alu_shift_seq #(
    parameter int AMOUNT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                dir,
    input  logic [AMOUNT_W-1:0] amount,
    input  logic [15:0]         operand,
    output logic [15:0]         alu_a,
    output logic [4:0]          alu_f,
    output logic                alu_notALUOE,
    output logic                alu_notShiftOE,
    input  logic [15:0]         alu_y,
    input  logic                alu_cout,
    output logic                busy,
    output logic                done,
    output logic [15:0]         result,
    output logic                cout,
    output logic                zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [AMOUNT_W-1:0] CNT_ZERO = '0;
    localparam logic [AMOUNT_W-1:0] CNT_ONE  = AMOUNT_W'(1);

    state_t                state_q, state_d;
    logic [15:0]           work_q, work_d;
    logic [AMOUNT_W-1:0]   cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic                  c_q, c_d;
    logic [15:0]           result_q, result_d;
    logic                  cout_q, cout_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            work_q   <= 16'h0000;
            cnt_q    <= CNT_ZERO;
            dir_q    <= 1'b0;
            c_q      <= 1'b0;
            result_q <= 16'h0000;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            c_q      <= c_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    // Next-state and datapath updates. result/cout are loaded on entry to DONE,
    // so they hold the previous answer throughout SHIFT.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        c_d      = c_q;
        result_d = result_q;
        cout_d   = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = operand;
                    cnt_d  = amount;
                    dir_d  = dir;
                    c_d    = 1'b0;
                    if (amount == CNT_ZERO) begin
                        // Zero-step shift: the answer is the operand itself.
                        state_d  = S_DONE;
                        result_d = operand;
                        cout_d   = 1'b0;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = alu_y;
                c_d    = alu_cout;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_DONE;
                    result_d = alu_y;
                    cout_d   = alu_cout;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ALU control pins. The shift output enable is only ever asserted in SHIFT,
    // which leaves the yout bus free for other drivers at all other times.
    always_comb begin
        alu_a          = work_q;
        alu_f          = dir_q ? `ALU_F_SHIFT_LEFT : `ALU_F_SHIFT_RIGHT;
        alu_notALUOE   = 1'b1;
        alu_notShiftOE = (state_q == S_SHIFT) ? 1'b0 : 1'b1;
    end

    // Status and result outputs.
    always_comb begin
        busy   = (state_q == S_SHIFT) || (state_q == S_DONE);
        done   = (state_q == S_DONE);
        result = result_q;
        cout   = cout_q;
        zero   = (result_q == 16'h0000);
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq. It models the external 1-bit ALU shifter and
// runs directed table vectors, hand-written corner sequences and random ops.
// Every result is compared against a plain-arithmetic shift reference.

`ifndef ALU_F_SHIFT_LEFT
`define ALU_F_SHIFT_LEFT  5'h1A
`endif
`ifndef ALU_F_SHIFT_RIGHT
`define ALU_F_SHIFT_RIGHT 5'h1B
`endif

module tb_alu_shift_seq;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset, start, dir;
    logic [AW-1:0] amount;
    logic [15:0]   operand;
    logic [15:0]   alu_a, alu_y;
    logic [4:0]    alu_f;
    logic          alu_notALUOE, alu_notShiftOE, alu_cout;
    logic          busy, done, cout, zero;
    logic [15:0]   result;

    int errors = 0;
    int checks = 0;

    alu_shift_seq #(.AMOUNT_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .dir(dir),
        .amount(amount), .operand(operand),
        .alu_a(alu_a), .alu_f(alu_f), .alu_notALUOE(alu_notALUOE),
        .alu_notShiftOE(alu_notShiftOE), .alu_y(alu_y), .alu_cout(alu_cout),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
    );

    always #5 clock = ~clock;

    // External ALU shifter: one-bit zero-filled shift with the lost bit on cout.
    always_comb begin
        if (alu_f == `ALU_F_SHIFT_LEFT) begin
            alu_y    = {alu_a[14:0], 1'b0};
            alu_cout = alu_a[15];
        end else begin
            alu_y    = {1'b0, alu_a[15:1]};
            alu_cout = alu_a[0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: a full shift done in one step with plain arithmetic.
    function automatic logic [16:0] ref_shift(input logic [15:0] op, input logic d, input int a);
        logic [31:0] w;
        logic [15:0] r;
        logic        c;
        w = {16'h0, op};
        if (a == 0) begin
            r = op; c = 1'b0;
        end else if (d) begin
            r = 16'((w << a) & 32'hFFFF);
            c = w[16 - a];
        end else begin
            r = 16'(w >> a);
            c = w[a - 1];
        end
        return {c, r};
    endfunction

    // Issue one op, scramble inputs after acceptance, and wait (bounded) for done.
    // Returns at the falling edge of the done cycle.
    task automatic run_op(input logic [15:0] op, input logic d, input logic [AW-1:0] a,
                          output int lat, output int oe_low, output logic fok);
        logic [4:0] fexp;
        fexp = d ? `ALU_F_SHIFT_LEFT : `ALU_F_SHIFT_RIGHT;
        @(negedge clock);
        operand = op; dir = d; amount = a; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; operand = 16'($urandom); dir = 1'($urandom); amount = AW'($urandom);
        lat = 1; oe_low = 0; fok = 1'b1;
        while (!done && lat < 40) begin
            if (!alu_notShiftOE) begin
                oe_low++;
                if (alu_f !== fexp || alu_notALUOE !== 1'b1) fok = 1'b0;
            end
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0]   op;
        logic          d;
        logic [AW-1:0] a;
        logic [15:0]   res;
        logic          co;
        int            lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat, oe_low, n;
        logic fok;
        logic [16:0] m;

        vecs[0] = '{16'h1234, 1'b1, 4'd4,  16'h2340, 1'b1, 5};
        vecs[1] = '{16'h8001, 1'b0, 4'd1,  16'h4000, 1'b1, 2};
        vecs[2] = '{16'hBEEF, 1'b1, 4'd0,  16'hBEEF, 1'b0, 1};
        vecs[3] = '{16'hFFFF, 1'b1, 4'd15, 16'h8000, 1'b1, 16};
        vecs[4] = '{16'h0001, 1'b0, 4'd1,  16'h0000, 1'b1, 2};

        reset = 1'b1; start = 1'b0; dir = 1'b1; amount = '0; operand = 16'hA5A5;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 16'h0);
        chk("rst_cout", cout, 0);
        chk("rst_zero", zero, 1);
        chk("rst_shiftoe", alu_notShiftOE, 1);
        chk("rst_aluoe", alu_notALUOE, 1);
        chk("rst_f", alu_f, `ALU_F_SHIFT_RIGHT);
        chk("rst_alu_a", alu_a, 16'h0);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].op, vecs[i].d, vecs[i].a, lat, oe_low, fok);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_cout", i), cout, vecs[i].co);
            chk($sformatf("vec%0d_zero", i), zero, (vecs[i].res == 16'h0));
            chk($sformatf("vec%0d_oe_low", i), oe_low, vecs[i].lat - 1);
            chk($sformatf("vec%0d_alu_f", i), fok, 1);
            @(negedge clock);
            chk($sformatf("vec%0d_idle_after", i), {busy, done}, 2'b00);
        end

        // Start held through SHIFT and DONE must be ignored, not queued.
        @(negedge clock);
        operand = 16'h00F0; dir = 1'b0; amount = 4'd3; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        operand = 16'hFFFF; dir = 1'b1; amount = 4'd1;
        n = 1;
        while (!done && n < 40) begin
            @(posedge clock); @(negedge clock); n++;
        end
        chk("busy_ign_latency", n, 4);
        chk("busy_ign_result", result, 16'h001E);
        chk("busy_ign_cout", cout, 0);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        chk("busy_ign_drop", {busy, done}, 2'b00);
        @(posedge clock);
        @(negedge clock);
        chk("done_ign_noqueue", {busy, done}, 2'b00);
        chk("done_ign_result", result, 16'h001E);

        // Reset during the second SHIFT cycle of an 8-step op.
        @(negedge clock);
        operand = 16'h00FF; dir = 1'b1; amount = 4'd8; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        chk("abort_shifting", alu_notShiftOE, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 16'h0);
        chk("abort_zero", zero, 1);
        chk("abort_shiftoe", alu_notShiftOE, 1);
        chk("abort_f", alu_f, `ALU_F_SHIFT_RIGHT);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); @(negedge clock);
            if (done || busy) n++;
        end
        chk("abort_no_done", n, 0);
        run_op(16'h00FF, 1'b1, 4'd8, lat, oe_low, fok);
        chk("abort_fresh_latency", lat, 9);
        chk("abort_fresh_result", result, 16'hFF00);
        chk("abort_fresh_cout", cout, 0);

        // Random ops against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] op;
            logic        d;
            int          a;
            op = 16'($urandom);
            d  = 1'($urandom);
            a  = $urandom_range(0, 15);
            if (i % 8 == 0) op = 16'(1 << $urandom_range(0, 15));
            m = ref_shift(op, d, a);
            run_op(op, d, AW'(a), lat, oe_low, fok);
            chk($sformatf("rnd%0d_latency", i), lat, a + 1);
            chk($sformatf("rnd%0d_result", i), result, m[15:0]);
            chk($sformatf("rnd%0d_cout", i), cout, m[16]);
            chk($sformatf("rnd%0d_zero", i), zero, (m[15:0] == 16'h0));
            chk($sformatf("rnd%0d_oe_low", i), oe_low, a);
            chk($sformatf("rnd%0d_alu_f", i), fok, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
- Multi-cycle barrel-shift controller for the 16-bit ALU.
- The ALU shifter moves one bit per operation. This block sequences it: it drives the shift function codes, feeds the working value into the ALU A input, and captures yout/cout back each clock.
- Delivers a logical shift left/right by 0..(2^AMOUNT_W-1) positions.
- Sits between the microcode control unit (start/operands) and the ALU control pins.

Parameters:
- AMOUNT_W, 4, width of shift-amount input; maximum shift = 2^AMOUNT_W-1 (15 by default).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dir  input  1  1 = shift left, 0 = shift right; latched at start.
- amount  input  AMOUNT_W  number of single-bit shifts; latched at start.
- operand  input  16  value to shift; latched at start.
- alu_a  output  16  drives ALU a; always the working register.
- alu_f  output  5  ALU function code: `ALU_F_SHIFT_LEFT / `ALU_F_SHIFT_RIGHT per latched dir.
- alu_notALUOE  output  1  constant 1; this block never enables the 181 path.
- alu_notShiftOE  output  1  0 only in SHIFT state, else 1.
- alu_y  input  16  ALU yout.
- alu_cout  input  1  ALU cout.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse in DONE.
- result  output  16  shifted value; held until next accepted start.
- cout  output  1  last bit shifted out; 0 if amount==0.
- zero  output  1  result == 16'h0000, combinational from result.

Behaviour:
- Reset: state=IDLE, work=0, cnt=0, dir_q=0, c_q=0. Outputs: busy=0, done=0, result=0, cout=0, zero=1, alu_notShiftOE=1, alu_notALUOE=1, alu_f=`ALU_F_SHIFT_RIGHT.
- Reset mid-operation aborts immediately; the next cycle is IDLE with the values above. No done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 then work<=operand, cnt<=amount, dir_q<=dir, c_q<=0.
  - Next state is DONE if amount==0, else SHIFT.
  - If start=0, stay in IDLE.
- SHIFT:
  - Drive alu_notShiftOE=0, alu_a=work, alu_f from dir_q.
  - Each edge: work<=alu_y, c_q<=alu_cout, cnt<=cnt-1.
  - When cnt==1 at the edge, go to DONE.
- DONE: done=1 for exactly one cycle. result=work, cout=c_q. Next state is IDLE.
- result/cout are registered copies updated on entry to DONE. They do not track work during SHIFT.
- Latency: done is high in the cycle following edge (amount+1) after the edge that sampled start. Examples: amount=0 gives 1 cycle; amount=15 gives 16 cycles.
- start while busy is ignored and not queued. start in the DONE cycle is ignored; a new start is accepted from IDLE, giving back-to-back throughput of amount+2 cycles.
- No width growth: the shift is logical and zero-filled, as provided by the ALU.
- alu_notShiftOE must never be 0 outside SHIFT, so the yout bus is released for other drivers.
- Inputs dir/amount/operand changing after start has no effect on the current operation.

Test Plan:
- Reset held 2 cycles, then start with operand=16'h1234, dir=1, amount=4. Required: done at cycle 5 after start, result=16'h2340, cout=1, zero=0. alu_notShiftOE low for exactly 4 cycles.
- Right shift: operand=16'h8001, dir=0, amount=1. Required: result=16'h4000, cout=1, done 2 cycles after start.
- amount=0 with operand=16'hBEEF. Required: done next cycle, result=16'hBEEF, cout=0, alu_notShiftOE never asserted.
- Full-range shift: operand=16'hFFFF, dir=1, amount=15. Required: result=16'h8000, cout=1, done 16 cycles after start. Follow with operand=16'h0001, dir=0, amount=1: result=0, zero=1, cout=1.
- Start pulses during busy and during the DONE cycle are ignored. Result matches the first request only, and busy drops the cycle after done.
- Assert reset during SHIFT (cycle 2 of an amount=8 op). Required: next cycle IDLE, busy=0, result=0, no done pulse. A fresh start then completes normally.
